// File: rtl/video_stream_sink_pkg.sv
// Shared types and defaults for the video stream sink: sink state encoding,
// default bus widths and the raster-size helper used for the last-pixel compare.
package video_stream_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } sink_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 19;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/video_stream_sink_if.sv
// Avalon-ST style pixel stream: the source drives the beat, the sink drives ready
// (ready latency 0).
interface video_stream_sink_if
    import video_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  stream_valid;
    logic                  stream_ready;
    logic                  stream_start;
    logic                  stream_end;
    logic [DATA_WIDTH-1:0] stream_data;

    modport master (
        output stream_valid,
        output stream_start,
        output stream_end,
        output stream_data,
        input  stream_ready
    );

    modport slave (
        input  stream_valid,
        input  stream_start,
        input  stream_end,
        input  stream_data,
        output stream_ready
    );

endinterface

// File: rtl/video_stream_sink.sv
// Packetized pixel sink: writes each framed beat to a linear frame-buffer port,
// checks SOP/EOP placement against the raster size and counts completed frames.
module video_stream_sink
    import video_stream_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    video_stream_sink_if.slave    stream,
    input  logic                  wr_full,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  sop_error,
    output logic                  eop_error,
    input  logic                  clear_errors
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX =
        ADDR_WIDTH'(frame_pixels(WIDTH, HEIGHT) - 1);

    sink_state_t           state_reg;
    logic [ADDR_WIDTH-1:0] index_reg;
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic                  frame_done_reg;
    logic [15:0]           frame_count_reg;
    logic                  sop_error_reg;
    logic                  eop_error_reg;

    logic                  ready;
    logic                  transfer;
    logic                  beat_taken;
    logic [ADDR_WIDTH-1:0] beat_index_next;
    logic                  beat_is_last;

    // Ready depends only on state and wr_full, never on stream_valid.
    assign ready               = (state_reg == IDLE) | ~wr_full;
    assign stream.stream_ready = ready;

    always_comb begin
        transfer        = stream.stream_valid & ready;
        beat_taken      = transfer & (stream.stream_start | (state_reg == ACTIVE));
        beat_index_next = stream.stream_start ? '0 : index_reg;
        beat_is_last    = (beat_index_next == LAST_INDEX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            index_reg       <= '0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
            sop_error_reg   <= 1'b0;
            eop_error_reg   <= 1'b0;
        end else begin
            wr_en_reg      <= beat_taken;
            frame_done_reg <= 1'b0;

            if (clear_errors) begin
                sop_error_reg <= 1'b0;
                eop_error_reg <= 1'b0;
            end

            // Error sets below come after the clear so a new error wins.
            if (beat_taken) begin
                wr_addr_reg <= beat_index_next;
                wr_data_reg <= stream.stream_data;

                if ((state_reg == ACTIVE) && stream.stream_start) begin
                    sop_error_reg <= 1'b1;
                end

                if (beat_is_last && stream.stream_end) begin
                    frame_done_reg  <= 1'b1;
                    frame_count_reg <= frame_count_reg + 16'd1;
                    state_reg       <= IDLE;
                    index_reg       <= '0;
                end else if (beat_is_last || stream.stream_end) begin
                    eop_error_reg <= 1'b1;
                    state_reg     <= IDLE;
                    index_reg     <= '0;
                end else begin
                    state_reg <= ACTIVE;
                    index_reg <= beat_index_next + 1'b1;
                end
            end
        end
    end

    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;
    assign sop_error   = sop_error_reg;
    assign eop_error   = eop_error_reg;

endmodule

// File: tb/tb_video_stream_sink.sv
// Randomized scoreboard bench for video_stream_sink on a 4x2 raster: stimulus pushes
// expected writes into a queue, a negedge monitor pops and compares.
module tb_video_stream_sink;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int FRAME = W * H;
    localparam int AW    = 19;
    localparam int DW    = 8;

    typedef struct {
        int          addr;
        logic [7:0]  data;
        bit          done;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_full = 1'b0;
    logic          clear_errors = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          sop_error;
    logic          eop_error;

    video_stream_sink_if #(.DATA_WIDTH(DW)) s_if ();

    video_stream_sink #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock        (clk),
        .reset        (rst),
        .stream       (s_if.slave),
        .wr_full      (wr_full),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .sop_error    (sop_error),
        .eop_error    (eop_error),
        .clear_errors (clear_errors)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;

    // Reference model state: where we are in the raster and what the flags should be.
    bit  m_in_frame = 0;
    int  m_next     = 0;
    bit  m_sop      = 0;
    bit  m_eop      = 0;
    int  m_count    = 0;
    bit  last_xfer  = 0;
    bit  started    = 0;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit  xfer;
        bit  new_sop;
        bit  new_eop;
        int  pos;
        wr_t e;
        started = 1;
        xfer    = 0;
        new_sop = 0;
        new_eop = 0;
        if (rst) begin
            m_in_frame = 0;
            m_next     = 0;
            m_sop      = 0;
            m_eop      = 0;
            m_count    = 0;
        end else begin
            xfer = s_if.stream_valid && (!m_in_frame || !wr_full);
            if (xfer && (s_if.stream_start || m_in_frame)) begin
                if (s_if.stream_start) begin
                    new_sop = m_in_frame;
                    pos     = 0;
                end else begin
                    pos = m_next;
                end
                e.addr = pos;
                e.data = s_if.stream_data;
                e.done = (pos == FRAME - 1) && s_if.stream_end;
                exp_q.push_back(e);
                if (e.done) m_count = (m_count + 1) % 65536;
                if ((pos == FRAME - 1) || s_if.stream_end) begin
                    new_eop    = !e.done;
                    m_in_frame = 0;
                    m_next     = 0;
                end else begin
                    m_in_frame = 1;
                    m_next     = pos + 1;
                end
            end
            if (clear_errors) begin
                m_sop = 0;
                m_eop = 0;
            end
            if (new_sop) m_sop = 1;
            if (new_eop) m_eop = 1;
        end
        last_xfer = xfer;
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        if (started) begin
            chk("ready", s_if.stream_ready, (!m_in_frame || !wr_full));
            chk("wr_en", wr_en, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (wr_en === 1'b1) begin
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("frame_done", frame_done, e.done);
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            chk("sop_error", sop_error, m_sop);
            chk("eop_error", eop_error, m_eop);
            chk("frame_count", frame_count, m_count);
        end
    end

    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d,
                         input logic f, input logic c);
        s_if.stream_valid = v;
        s_if.stream_start = s;
        s_if.stream_end   = e;
        s_if.stream_data  = d;
        wr_full           = f;
        clear_errors      = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 0, 0, 8'h00, 0, 0);
            tick();
        end
    endtask

    task automatic clear_flags();
        drive(0, 0, 0, 8'h00, 0, 1);
        tick();
        drive(0, 0, 0, 8'h00, 0, 0);
    endtask

    // Holds one beat until accepted, with optional idle gaps and random wr_full.
    task automatic send_beat(input logic s, input logic e, input logic [7:0] d,
                             input int full_pct, input int gap_pct, input logic c = 1'b0);
        int tries = 0;
        while (($urandom_range(99) < gap_pct) && tries < 20) begin
            drive(0, 0, 0, 8'($urandom), $urandom_range(99) < full_pct, 0);
            tick();
            tries++;
        end
        tries = 0;
        do begin
            drive(1, s, e, d, (tries < 50) && ($urandom_range(99) < full_pct), c);
            tick();
            tries++;
        end while (!last_xfer && tries < 100);
        if (!last_xfer) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: beat %0h not accepted after %0d cycles", d, tries);
        end
        drive(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic send_frame(input int base, input int full_pct, input int gap_pct);
        for (int k = 0; k < FRAME; k++) begin
            send_beat(k == 0, k == FRAME - 1, 8'(base + k), full_pct, gap_pct);
        end
    endtask

    // Beats offered during reset must be discarded.
    task automatic do_reset(input int n);
        repeat (n) begin
            rst = 1'b1;
            drive(1, 1, 0, 8'hAA, 0, 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 8'h00, 0, 0);
        chk("wr_en_after_reset", wr_en, 0);
    endtask

    initial begin
        drive(0, 0, 0, 8'h00, 0, 0);
        rst = 1'b1;
        tick();
        do_reset(3);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_count", frame_count, 0);
        chk("reset_sop", sop_error, 0);
        chk("reset_eop", eop_error, 0);
        idle(2);

        // Clean frame
        send_frame(0, 0, 0);
        idle(2);
        chk("clean_count", frame_count, 1);
        chk("clean_sop", sop_error, 0);
        chk("clean_eop", eop_error, 0);

        // Junk before SOP is dropped
        for (int k = 0; k < 3; k++) send_beat(0, 0, 8'(8'hF0 + k), 0, 0);
        send_frame(8'h10, 0, 0);
        idle(2);
        chk("junk_count", frame_count, 2);

        // Early EOP on beat 4
        for (int k = 0; k < 5; k++) send_beat(k == 0, k == 4, 8'(8'h20 + k), 0, 0);
        idle(2);
        chk("early_eop_flag", eop_error, 1);
        chk("early_eop_count", frame_count, 2);
        send_frame(8'h30, 0, 0);
        idle(2);
        chk("after_eop_count", frame_count, 3);
        chk("eop_sticky", eop_error, 1);
        clear_flags();
        chk("eop_cleared", eop_error, 0);

        // SOP again on beat 3 restarts the frame
        for (int k = 0; k < 3; k++) send_beat(k == 0, 0, 8'(8'h40 + k), 0, 0);
        send_frame(8'h50, 0, 0);
        idle(2);
        chk("mid_sop_flag", sop_error, 1);
        chk("mid_sop_count", frame_count, 4);
        clear_flags();

        // SOP and EOP on the same beat
        send_beat(1, 1, 8'h60, 0, 0);
        idle(2);
        chk("sop_eop_same_eop", eop_error, 1);
        chk("sop_eop_same_count", frame_count, 4);
        clear_flags();

        // Clear in the same cycle as a new error: set wins
        send_beat(1, 0, 8'h70, 0, 0);
        send_beat(0, 1, 8'h71, 0, 0, 1'b1);
        idle(2);
        chk("clear_vs_set", eop_error, 1);
        clear_flags();

        // Backpressure and gaps
        for (int f = 0; f < 50; f++) send_frame(f * 8, 40, 20);
        idle(3);
        chk("bp_count", frame_count, 54);
        chk("bp_sop", sop_error, 0);
        chk("bp_eop", eop_error, 0);

        // Reset in the middle of a frame
        for (int k = 0; k < 5; k++) send_beat(k == 0, 0, 8'(8'h80 + k), 0, 0);
        do_reset(1);
        send_frame(8'h90, 0, 0);
        idle(2);
        chk("mid_reset_count", frame_count, 1);
        chk("mid_reset_sop", sop_error, 0);
        chk("mid_reset_eop", eop_error, 0);

        // Unconstrained random traffic
        repeat (600) begin
            rst = ($urandom_range(99) == 0);
            drive($urandom_range(99) < 70, $urandom_range(99) < 12, $urandom_range(99) < 12,
                  8'($urandom), $urandom_range(99) < 30, $urandom_range(99) < 5);
            tick();
        end
        rst = 1'b0;
        idle(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_stream_sink.md
# video_stream_sink

Avalon-ST video sink: consumes the 8-bit packetized pixel stream produced by the pixel iterator / solver path (valid, ready, startofpacket, endofpacket, data) and writes each accepted pixel into a linear frame-buffer write port. Tracks framing against the configured raster size, flags framing errors, and counts completed frames. Used as an on-FPGA stand-in for the Qsys video sink in simulation and for frame-capture/self-check builds.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- DATA_WIDTH, 8, pixel data bits
- ADDR_WIDTH, 19, write address bits; must satisfy 2^ADDR_WIDTH >= WIDTH*HEIGHT
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- stream_ready  out  1  sink ready (ready latency 0)
- stream_valid  in  1  beat valid
- stream_start  in  1  startofpacket
- stream_end  in  1  endofpacket
- stream_data  in  DATA_WIDTH  pixel value
- wr_full  in  1  frame buffer cannot take a write on the next cycle
- wr_en  out  1  registered write strobe
- wr_addr  out  ADDR_WIDTH  linear pixel index, y*WIDTH + x
- wr_data  out  DATA_WIDTH  pixel value
- frame_done  out  1  one-cycle pulse on a correctly framed last pixel
- frame_count  out  16  completed frames, wraps 0xFFFF -> 0
- sop_error  out  1  sticky: startofpacket seen mid-frame
- eop_error  out  1  sticky: endofpacket early, or missing on last pixel
- clear_errors  in  1  clears both sticky error flags

## Operation
- Transfer = stream_valid & stream_ready. Nothing else has an effect.
- States: IDLE (hunting for SOP), ACTIVE (inside a frame).
- stream_ready = 1 in IDLE; = ~wr_full in ACTIVE.
- IDLE, transfer with start=0: beat dropped, no write, no error.
- IDLE, transfer with start=1: write pixel at index 0, go ACTIVE with next index 1.
- ACTIVE, transfer with start=1: sop_error set; beat written as index 0; frame restarts; stay ACTIVE.
- ACTIVE, transfer with end=1 and index != WIDTH*HEIGHT-1: beat written, eop_error set, go IDLE, no frame_done.
- ACTIVE, transfer at index WIDTH*HEIGHT-1 with end=0: beat written, eop_error set, go IDLE, no frame_done.
- ACTIVE, transfer at last index with end=1: beat written, frame_done pulse, frame_count+1, go IDLE.
- start=1 and end=1 on the same beat: start handled first (index 0), then end rule applies; with WIDTH*HEIGHT>1 this gives eop_error and IDLE.
- Index held as one linear counter (no multiplier); compares against constant WIDTH*HEIGHT-1.
- clear_errors and a new error in the same cycle: set wins.

## Timing
- Write latency 1: transfer in cycle N -> wr_en/wr_addr/wr_data valid in cycle N+1, for exactly one cycle.
- frame_done and frame_count update are in the same cycle as the last pixel's wr_en.
- stream_ready is combinational from state and wr_full; no path from stream_valid to stream_ready.
- Back-to-back transfers sustain one write per cycle while wr_full=0.
- Reset values: state IDLE, index 0, wr_en 0, wr_addr 0, wr_data 0, frame_done 0, frame_count 0, sop_error 0, eop_error 0. stream_ready is 1 during reset cycles since state is IDLE; beats accepted during reset are discarded.
- Reset mid-frame: partial frame abandoned, no error raised, wr_en low on the cycle after reset.

## Structure
- Shared package video_stream_pkg: state enum (IDLE, ACTIVE), DATA_WIDTH/ADDR_WIDTH defaults, frame-size constant function.
- Single module. No sub-module; the index counter is part of the same always block.

## Test plan
- Clean 4x2 frame (WIDTH=4, HEIGHT=2): 8 beats data 0..7, sop on beat 0, eop on beat 7 -> wr_addr 0..7 with wr_data 0..7, frame_done once, frame_count=1, no errors.
- Pre-SOP junk: 3 beats without sop, then a clean frame -> no writes for the junk, then the frame is captured normally.
- Early EOP: eop on beat 4 of a 4x2 frame -> writes at 0..4, eop_error=1, frame_count unchanged; next sop frame captured from address 0.
- Mid-frame SOP: sop again on beat 3 -> sop_error=1, that beat written at address 0, frame completes 8 beats later with frame_done.
- Backpressure: toggle wr_full randomly during the 640x480 frame -> no transfer while ready=0, all 307200 addresses written in order, exactly one frame_done.
- Reset at beat 100 of a frame, then a clean frame -> no error flags, frame_count=1, wr_en low on the cycle after reset.
